// File: rtl/vga_mode_ctrl.sv
// Pattern-select control for the VGA generator: debounced NEXT/PREV buttons
// and optional auto-cycling, with selection changes applied at vsync start.
module vga_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_FRAMES     = 120,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_raw,
    input  logic       vsync,
    input  logic       auto_en,
    output logic [1:0] mode,
    output logic [1:0] pending_mode,
    output logic       mode_changed,
    output logic [1:0] key_pressed
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int FR_W = $clog2(AUTO_FRAMES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FR_W-1:0] FR_LAST  = FR_W'(AUTO_FRAMES - 1);
    localparam logic [1:0]      KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    logic [1:0]      key_s1, key_s2;
    logic            vs_s1, vs_s2, vs_s3;
    logic [1:0]      stable, stable_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [FR_W-1:0] frame_cnt;

    logic [1:0]      key_lvl;
    logic            frame_tick;
    logic            key_event;
    logic            auto_step;
    logic [1:0]      pending_next;
    logic [FR_W-1:0] frame_cnt_next;

    // Normalised so that 1 always means "pressed", independent of board polarity.
    assign key_lvl    = key_s2 ^ KEY_IDLE;
    assign frame_tick = vs_s3 & ~vs_s2;
    assign key_event  = |key_pressed;
    assign auto_step  = auto_en && frame_tick && (frame_cnt == FR_LAST) && !key_event;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        pending_next   = pending_mode;
        frame_cnt_next = frame_cnt;

        unique case (key_pressed)
            2'b01:   pending_next = pending_mode + 2'd1;
            2'b10:   pending_next = pending_mode - 2'd1;
            2'b11:   pending_next = pending_mode;
            default: if (auto_step) pending_next = pending_mode + 2'd1;
        endcase

        if (!auto_en || key_event) begin
            frame_cnt_next = '0;
        end else if (frame_tick) begin
            frame_cnt_next = (frame_cnt == FR_LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1       <= KEY_IDLE;
            key_s2       <= KEY_IDLE;
            vs_s1        <= 1'b1;
            vs_s2        <= 1'b1;
            vs_s3        <= 1'b1;
            stable       <= '0;
            stable_d     <= '0;
            db_cnt[0]    <= '0;
            db_cnt[1]    <= '0;
            frame_cnt    <= '0;
            mode         <= '0;
            pending_mode <= '0;
            mode_changed <= 1'b0;
            key_pressed  <= '0;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
            vs_s1  <= vsync;
            vs_s2  <= vs_s1;
            vs_s3  <= vs_s2;

            for (int i = 0; i < 2; i++) begin
                if (key_lvl[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= ~stable[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end

            stable_d     <= stable;
            key_pressed  <= stable & ~stable_d;
            pending_mode <= pending_next;
            frame_cnt    <= frame_cnt_next;

            // Apply uses the pre-update pending value, so a same-cycle key
            // event lands on the following frame.
            if (frame_tick && (pending_mode != mode)) begin
                mode         <= pending_mode;
                mode_changed <= 1'b1;
            end else begin
                mode_changed <= 1'b0;
            end
        end
    end

endmodule
